// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg: shared widths, reader FSM states and buffer sizing
package ram_stream_reader_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_RD_LAT = 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} rd_state_t;
  function automatic int buf_depth(input int lat);
    return lat + 1;
  endfunction
endpackage

// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: command, RAM read port and output stream of the reader
interface ram_stream_reader_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_adr;
  logic [DATA_W-1:0] ram_dout;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  modport master (
    input  start, base_addr, len, ram_dout, m_ready,
    output busy, done, ram_re, ram_adr, m_valid, m_data
  );
  modport slave (
    output start, base_addr, len, ram_dout, m_ready,
    input  busy, done, ram_re, ram_adr, m_valid, m_data
  );
endinterface

// File: rtl/ram_stream_reader_rd_skid_buf.sv
// rd_skid_buf: small FIFO that absorbs RAM words while the consumer stalls
module rd_skid_buf #(
  parameter int DEPTH = 2,
  parameter int DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_W-1:0]            din,
  input  logic                         pop,
  output logic [DATA_W-1:0]            dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_pop, do_push;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign dout = mem[rp];
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wp] <= din;
      if (do_push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (do_pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks len RAM addresses from base and streams the words
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input logic clk,
  input logic rst,
  ram_stream_reader_if.master bus
);
  localparam int DEPTH = buf_depth(RD_LAT);
  localparam int CW = $clog2(DEPTH + 1);
  rd_state_t state;
  logic [ADDR_W:0] rem;
  logic [ADDR_W-1:0] nxt, last;
  logic [RD_LAT-1:0] dl;
  logic [CW-1:0] ni, cnt;
  logic empty, full, pop, arrive;
  assign arrive = dl[RD_LAT-1];
  assign bus.m_valid = !empty;
  assign pop = bus.m_valid && bus.m_ready;
  // a word leaving this cycle frees its slot, which keeps one word per cycle
  assign bus.ram_re = state == RUN && (!full || pop) && (cnt + ni - CW'(pop)) < CW'(DEPTH);
  assign bus.ram_adr = bus.ram_re ? nxt : last;
  rd_skid_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_buf (
    .clk(clk),
    .rst(rst),
    .push(arrive),
    .din(bus.ram_dout),
    .pop(pop),
    .dout(bus.m_data),
    .full(full),
    .empty(empty),
    .count(cnt)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      rem <= '0;
      nxt <= '0;
      last <= '0;
      dl <= '0;
      ni <= '0;
    end else begin
      dl <= RD_LAT'({dl, bus.ram_re});
      ni <= ni + CW'(bus.ram_re) - CW'(arrive);
      if (bus.ram_re) begin
        last <= nxt;
        nxt <= nxt + 1'b1;
        rem <= rem - 1'b1;
      end
      case (state)
        IDLE: if (bus.start) begin
          nxt <= bus.base_addr;
          rem <= bus.len;
          state <= bus.len == '0 ? FIN : RUN;
          bus.busy <= 1'b1;
          bus.done <= bus.len == '0;
        end
        RUN: if (bus.ram_re && rem == (ADDR_W+1)'(1)) state <= DRAIN;
        DRAIN: if (ni == '0 && (cnt == '0 || (cnt == CW'(1) && pop))) begin
          state <= FIN;
          bus.done <= 1'b1;
        end
        default: begin
          state <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end
endmodule
